// File: rtl/digit_serial_adder_pkg.sv
// Shared types and helpers for the digit-serial arithmetic blocks.
// Holds the control FSM state encoding and the digit-counter sizing rule.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A single-digit configuration still gets a 1-bit counter.
  function automatic int cnt_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/digit_serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple adder built from full-adder cells.
// Also exposes the carry into the top bit for signed-overflow detection.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract: DIGIT bits per clock with a registered carry.
// Valid/ready on both sides; result held in DONE until the consumer takes it.
module digit_serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $fatal(1, "digit_serial_adder: DIGIT must divide WIDTH");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout, dig_cmsb;
  logic [WIDTH-1:0] res_full;
  logic             accept;

  digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .cin  (carry_q),
    .sum  (dig_sum),
    .cout (dig_cout),
    .c_msb(dig_cmsb)
  );

  // res_full is the complete result assuming the current digit is the last one.
  if (NDIG == 1) begin : g_one_digit
    assign res_full = dig_sum;
  end else begin : g_multi_digit
    logic [WIDTH-DIGIT-1:0] res_q, res_d;

    assign res_full = {dig_sum, res_q};

    always_comb begin
      res_d = res_q;
      if (state_q == RUN) res_d = res_full[WIDTH-1 -: WIDTH-DIGIT];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) res_q <= '0;
      else        res_q <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  // NOTE: every variable gets its hold value first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: ;
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dig_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NDIG - 1)) begin
          state_d = DONE;
          s_d     = res_full;
          cout_d  = dig_cout;
          ovf_d   = dig_cout ^ dig_cmsb;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Subtraction runs as a + ~b + !cin, so b is inverted once on load.
    if (accept) begin
      state_d = RUN;
      cnt_d   = '0;
      a_d     = a;
      b_d     = b ^ {WIDTH{sub}};
      carry_d = cin ^ sub;
    end
  end

  // NOTE: sequential state uses non-blocking <= so all flops sample pre-edge values.
  // NOTE: operand and result registers are reset too, so s/cout/ovf read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench: directed tests on a 32/4 instance plus randomized
// parameter sweeps, all checked against an arithmetic reference model.
module tb_digit_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit values, signed range test for ovf.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub, input int acc);
    exp_t e;
    longint unsigned m  = (64'd1 << w) - 64'd1;
    longint unsigned ua = {32'd0, a} & m;
    longint unsigned ub = {32'd0, b} & m;
    longint unsigned uc = {63'd0, cin};
    longint sa = (((ua >> (w - 1)) & 64'd1) != 0) ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    longint sb = (((ub >> (w - 1)) & 64'd1) != 0) ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    longint lo = -(longint'(1) << (w - 1));
    longint hi = (longint'(1) << (w - 1)) - 1;
    longint unsigned r;
    longint t;
    if (!sub) begin
      r      = ua + ub + uc;
      t      = sa + sb + longint'(uc);
      e.cout = ((r >> w) & 64'd1) != 0;
    end else begin
      r      = ua - ub - uc;
      t      = sa - sb - longint'(uc);
      e.cout = (ua >= ub + uc);
    end
    e.s   = 32'(r & m);
    e.ovf = (t < lo) || (t > hi);
    e.acc = acc;
    return e;
  endfunction

  // ---------------- main 32/4 instance ----------------
  localparam int NDIG_M = 8;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, s;
  logic        cin, sub, cout, ovf;

  digit_serial_adder #(.WIDTH(32), .DIGIT(4)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s        (s),
    .cout     (cout),
    .ovf      (ovf)
  );

  exp_t q[$];
  bit   presented = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) presented = 1'b0;
    else if (out_valid) begin
      if (!presented) begin
        presented = 1'b1;
        if (q.size() == 0) check("main_unexpected_out", 64'(q.size()), 64'd1);
        else begin
          e = q.pop_front();
          check("main_s", 64'(s), 64'(e.s));
          check("main_cout", 64'(cout), 64'(e.cout));
          check("main_ovf", 64'(ovf), 64'(e.ovf));
          check("main_latency", 64'(cyc - e.acc), 64'(NDIG_M));
        end
      end
      if (out_ready) presented = 1'b0;
    end
  end

  task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic vc, input logic vs);
    int n = 0;
    a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) check("main_accept_timeout", 64'(in_ready), 64'd1);
    else q.push_back(model(32, va, vb, vc, vs, cyc + 1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("main_drain_left", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // ---------------- parameter sweep instances ----------------
  localparam int NS = 4;
  localparam int SW[NS] = '{32, 32, 8, 12};
  localparam int SD[NS] = '{1, 32, 2, 3};
  localparam int NOPS   = 1000;

  logic rst_sw_n;
  int   sweep_done = 0;

  for (genvar g = 0; g < NS; g++) begin : g_sw
    localparam int W = SW[g];
    localparam int D = SD[g];

    logic         iv, ir, ov, ordy, ci, sb, co, of;
    logic [W-1:0] xa, xb, xs;
    logic [W-1:0] hs;
    logic         hc, ho;
    exp_t         sq[$];
    bit           pres = 1'b0;

    digit_serial_adder #(.WIDTH(W), .DIGIT(D)) u_sw (
      .clk      (clk),
      .rst_n    (rst_sw_n),
      .in_valid (iv),
      .in_ready (ir),
      .a        (xa),
      .b        (xb),
      .cin      (ci),
      .sub      (sb),
      .out_valid(ov),
      .out_ready(ordy),
      .s        (xs),
      .cout     (co),
      .ovf      (of)
    );

    initial ordy = 1'b0;
    always @(posedge clk) begin
      #1;
      ordy = ($urandom % 3) != 0;
    end

    initial begin
      int n;
      iv = 1'b0; xa = '0; xb = '0; ci = 1'b0; sb = 1'b0;
      wait (rst_sw_n === 1'b1);
      for (int i = 0; i < NOPS; i++) begin
        @(posedge clk); #1;
        while ($urandom % 4 == 0) begin
          @(posedge clk); #1;
        end
        xa = W'($urandom);
        xb = W'($urandom);
        if (i % 10 == 0) xa = '1;
        if (i % 10 == 1) xa = {1'b1, {(W-1){1'b0}}};
        if (i % 10 == 2) xb = {1'b0, {(W-1){1'b1}}};
        ci = 1'($urandom);
        sb = 1'($urandom);
        iv = 1'b1;
        n  = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!ir && n < 4 * W + 20);
        if (!ir) begin
          check("sweep_accept_timeout", 64'(ir), 64'd1);
          break;
        end
        sq.push_back(model(W, 32'(xa), 32'(xb), ci, sb, cyc + 1));
        @(posedge clk); #1;
        iv = 1'b0;
        xa = W'($urandom);
        xb = W'($urandom);
      end
      n = 0;
      while ((sq.size() != 0 || ov) && n < 4 * W + 50) begin
        @(negedge clk);
        n++;
      end
      check("sweep_drain_left", 64'(sq.size()), 64'd0);
      sweep_done++;
    end

    always @(negedge clk) begin
      exp_t e;
      if (!rst_sw_n) pres = 1'b0;
      else if (ov) begin
        if (!pres) begin
          pres = 1'b1;
          hs = xs; hc = co; ho = of;
          if (sq.size() == 0) check("sweep_unexpected_out", 64'(sq.size()), 64'd1);
          else begin
            e = sq.pop_front();
            check("sweep_s", 64'(xs), 64'(e.s));
            check("sweep_cout", 64'(co), 64'(e.cout));
            check("sweep_ovf", 64'(of), 64'(e.ovf));
            check("sweep_latency", 64'(cyc - e.acc), 64'(W / D));
          end
        end else begin
          check("sweep_hold", 64'({co, of, xs}), 64'({hc, ho, hs}));
        end
        if (ordy) pres = 1'b0;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_sw_n = 1'b0;
    #23 rst_sw_n = 1'b1;
  end

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_s", 64'(s), 64'd0);
    check("reset_cout", 64'(cout), 64'd0);
    check("reset_ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    drain();
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    send(32'd5, 32'd7, 1'b0, 1'b1);
    drain();
    send(32'h8000_0000, 32'h1, 1'b0, 1'b1);
    send(32'd10, 32'd3, 1'b1, 1'b1);
    drain();

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("hold_reached_done", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      a = $urandom; b = $urandom; in_valid = ~in_valid;
      @(negedge clk);
      check("hold_s", 64'(s), 64'h2345_6789);
      check("hold_cout", 64'(cout), 64'd0);
      check("hold_ovf", 64'(ovf), 64'd0);
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'd3, 32'd4, 1'b0, 1'b0);
    drain();

    // Abort an in-flight operation with reset.
    send(32'hAAAA_5555, 32'h1234_5678, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_s", 64'(s), 64'd0);
    void'(q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(32'd1, 32'd2, 1'b0, 1'b0);
    drain();

    while (sweep_done < NS && cyc < 95000) @(negedge clk);
    check("sweeps_done", 64'(sweep_done), 64'(NS));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
